// File: rtl/mac_vec_pkg.sv
// Shared constants, op-codes and state type for the vector MAC sequencer.
// Op-code values must match the array's op field encoding.
package mac_vec_pkg;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int RW    = 19;
  localparam int LW    = 3;

  localparam logic [3:0]    LEN_MAX   = 4'd8;
  localparam logic [LW-1:0] LAST_LANE = 3'd7;

  localparam logic [1:0] OP_LOAD_W = 2'b00;
  localparam logic [1:0] OP_LOAD_A = 2'b01;
  localparam logic [1:0] OP_READ_S = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_W  = 3'd1,
    ST_LD_A  = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/mac_vec_sequencer.sv
// Job sequencer for the 8-lane MAC array: streams weights/activations,
// issues READ_S and reassembles the 3-byte result into a 19-bit sum.
module mac_vec_sequencer
  import mac_vec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_len,
  input  logic          cmd_reuse_w,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [1:0]    arr_op,
  output logic [5:0]    arr_addr,
  output logic [DW-1:0] arr_data,
  input  logic [7:0]    arr_dout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          busy
);

  seq_state_t    state_r;
  seq_state_t    state_s;
  logic [LW-1:0] lane_r;
  logic [3:0]    len_r;
  logic [1:0]    dcnt_r;
  logic [RW-1:0] res_data_r;
  logic          res_valid_r;

  logic lane_active_s;
  logic lane_last_w_s;
  logic lane_step_s;
  logic unused_hi_s;

  assign lane_active_s = ({1'b0, lane_r} < len_r);
  assign lane_last_w_s = ({1'b0, lane_r} == (len_r - 4'd1));
  // Padding lanes (beyond len) advance every cycle without waiting for input
  assign lane_step_s   = lane_active_s ? in_valid : 1'b1;
  assign unused_hi_s   = ^arr_dout[7:3];

  assign res_data  = res_data_r;
  assign res_valid = res_valid_r;

  // State register plus lane/drain counters and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      lane_r      <= 3'd0;
      len_r       <= 4'd0;
      dcnt_r      <= 2'd0;
      res_data_r  <= {RW{1'b0}};
      res_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_r  <= clamp_len(cmd_len);
            lane_r <= 3'd0;
          end
        end
        ST_LD_W: begin
          if (in_valid) begin
            lane_r <= lane_last_w_s ? 3'd0 : (lane_r + 3'd1);
          end
        end
        ST_LD_A: begin
          if (lane_step_s) begin
            lane_r <= lane_r + 3'd1;
          end
        end
        ST_READ: begin
          dcnt_r <= 2'd0;
        end
        ST_DRAIN: begin
          dcnt_r <= dcnt_r + 2'd1;
          case (dcnt_r)
            2'd1:    res_data_r[RW-1:2*DW]   <= arr_dout[RW-2*DW-1:0];
            2'd2:    res_data_r[2*DW-1:DW]   <= arr_dout;
            2'd3: begin
              res_data_r[DW-1:0] <= arr_dout;
              res_valid_r        <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_s = (!cmd_reuse_w && (clamp_len(cmd_len) != 4'd0)) ? ST_LD_W : ST_LD_A;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LD_W: begin
        if (in_valid && lane_last_w_s) begin
          state_s = ST_LD_A;
        end else begin
          state_s = ST_LD_W;
        end
      end
      ST_LD_A: begin
        if (lane_step_s && (lane_r == LAST_LANE)) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_LD_A;
        end
      end
      ST_READ:  state_s = ST_DRAIN;
      ST_DRAIN: begin
        if (dcnt_r == 2'd3) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Array port and handshake outputs; NOP unless a write or READ_S is due
  always_comb begin
    arr_op    = OP_NOP;
    arr_addr  = 6'd0;
    arr_data  = {DW{1'b0}};
    in_ready  = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LD_W: begin
        in_ready = 1'b1;
        if (in_valid) begin
          arr_op   = OP_LOAD_W;
          arr_addr = {3'd0, lane_r};
          arr_data = in_data;
        end else begin
          arr_op   = OP_NOP;
        end
      end
      ST_LD_A: begin
        if (lane_active_s) begin
          in_ready = 1'b1;
          if (in_valid) begin
            arr_op   = OP_LOAD_A;
            arr_addr = {3'd0, lane_r};
            arr_data = in_data;
          end else begin
            arr_op   = OP_NOP;
          end
        end else begin
          arr_op   = OP_LOAD_A;
          arr_addr = {3'd0, lane_r};
          arr_data = {DW{1'b0}};
        end
      end
      ST_READ:  arr_op = OP_READ_S;
      ST_DRAIN: arr_op = OP_NOP;
      ST_DONE:  arr_op = OP_NOP;
      default:  busy   = 1'b1;
    endcase
  end

endmodule

// File: doc/mac_vec_sequencer.md
Name: mac_vec_sequencer

Overview:
Command-driven sequencer for the 8-lane vector MAC/adder-tree array. It accepts a dot-product job (length, weight-reuse flag) and streams weight and activation bytes into the array's op/address/data port. It then issues READ_S, deserialises the 3-byte result the array returns high byte first, and presents a 19-bit sum on a valid/ready result port. It sits between a host-side byte stream and the array; it is the only driver of the array's control inputs.

Parameters:
LANES, 8, number of MAC lanes; must be 8 to match the array.
DW, 8, operand width in bits.
RW, 19, result width; equals 2*DW+log2(LANES).

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_len  in  4  active lanes; values above LANES are clamped to LANES; 0 is legal
cmd_reuse_w  in  1  1 = skip the weight phase and keep the weights already in the array
in_valid  in  1  operand byte valid
in_ready  out  1  sequencer consumes in_data this cycle
in_data  in  DW  operand byte; order is len weights (lane 0 first), then len activations
arr_op  out  2  to array op field: 00 LOAD_W, 01 LOAD_A, 10 READ_S, 11 NOP
arr_addr  out  6  to array address field (lane index, upper bits 0)
arr_data  out  DW  to array data_in
arr_dout  in  8  array data_out
res_valid  out  1  result available
res_ready  in  1  result taken
res_data  out  RW  dot-product sum
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lane counter=0, drain counter=0, res_data=0, res_valid=0. Combinational outputs follow the IDLE state: arr_op=NOP, arr_addr=0, arr_data=0, in_ready=0, cmd_ready=1, busy=0. Reset mid-job abandons the job; no partial result appears. The array shares rst_n.
- States: IDLE, LD_W, LD_A, READ, DRAIN, DONE.
- IDLE: on cmd_valid && cmd_ready, latch len_q=min(cmd_len,LANES) and lane=0. Next state is LD_W if (!cmd_reuse_w && len_q!=0), else LD_A.
- LD_W: in_ready=1. When in_valid=1: arr_op=LOAD_W, arr_addr=lane, arr_data=in_data, then lane++. When in_valid=0: arr_op=NOP and lane holds (stall). After lane len_q-1 is written: lane=0, go to LD_A. Weights for lanes >= len_q are not touched.
- LD_A: iterates all lanes 0..LANES-1, one lane per cycle.
  - lane < len_q: behaves like LD_W with LOAD_A, including stalls.
  - lane >= len_q: in_ready=0, arr_op=LOAD_A, arr_data=0, no stall. This zeroes unused products regardless of stale weights.
  - After lane LANES-1 is written, go to READ.
- READ: one cycle, arr_op=READ_S. Go to DRAIN with dcnt=0.
- DRAIN: four cycles (dcnt 0..3), arr_op=NOP throughout; a READ_S here would restart the array's readout. Capture on the clock edge:
  - dcnt=1: res_data[18:16] = arr_dout[2:0]
  - dcnt=2: res_data[15:8] = arr_dout
  - dcnt=3: res_data[7:0] = arr_dout, then go to DONE.
- DONE: res_valid=1, and res_data is stable until res_ready=1. On res_ready, go to IDLE (res_valid drops next cycle; res_data holds its value).
- Latency with no stalls, counted from the cmd accept cycle (cycle 0): W phase len_q cycles, A phase LANES cycles, READ 1, DRAIN 4. res_valid rises at cycle 1+W+LANES+5. len=8 gives cycle 22; reuse gives cycle 14.
- No overflow is possible: the maximum sum 8*255*255 = 0x7F008 fits in 19 bits.
- cmd_valid during a job is ignored (cmd_ready=0). in_valid outside the load phases is ignored (in_ready=0).

Decomposition:
- Package mac_vec_pkg holds:
  - op-code localparams OP_LOAD_W/OP_LOAD_A/OP_READ_S/OP_NOP, which must match the array's encoding
  - the seq_state_t enum
  - LANES and RW constants
- No sub-module is required. The 3-byte capture may be split out as mac_vec_result_capture if the team prefers.

Test Plan:
- len=8, reuse=0, w=1..8, a=1..8, in_valid always 1 -> res_data=204 (0x000CC), res_valid at cycle 22, 8 LOAD_W then 8 LOAD_A then exactly one READ_S.
- len=8, all operands 0xFF -> res_data=0x7F008.
- Follow-up job reuse=1, len=8, a=2 each, after w=1..8 -> res_data=72; no LOAD_W issued; res_valid at cycle 14.
- len=3, w=10,20,30, a=1,1,1 (lanes 3..7 hold old weights), in_valid toggling 1,0,1 -> res_data=60; arr_op=NOP on stall cycles; lanes 3..7 written LOAD_A 0.
- len=0 and len=12 -> len=0 yields res_data=0 with no in_ready; len=12 behaves as len=8.
- rst_n low during LD_A, then a new len=2 job (w=3,4, a=5,6) -> state IDLE, res_valid=0, arr_op=NOP immediately; next result=39; res_valid held across 5 cycles of res_ready=0.
